// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encoding and per-approach lamp decode shared by the traffic controller files
package traffic_pkg;

   localparam logic [1:0] PH_GREEN  = 2'd0;
   localparam logic [1:0] PH_YELLOW = 2'd1;
   localparam logic [1:0] PH_ALLRED = 2'd2;

   // one approach's lamps as {red, yellow, green}; only the owning approach can leave red
   function automatic logic [2:0] lamp_decode(input logic [1:0] ph, input logic own);
      return (own && ph == PH_GREEN)  ? 3'b001 :
             (own && ph == PH_YELLOW) ? 3'b010 : 3'b100;
   endfunction

endpackage

// File: rtl/traffic_light_controller_nway_rr_way_select.sv
// rr_way_select: combinational circular priority scan, first requesting way at or after start
module rr_way_select #(
   parameter int NUM_WAYS = 4
) (
   input  logic [NUM_WAYS-1:0]         req,
   input  logic [$clog2(NUM_WAYS)-1:0] start,
   output logic [$clog2(NUM_WAYS)-1:0] grant,
   output logic                        any_req
);

   localparam int W = $clog2(NUM_WAYS);

   logic [W-1:0] idx;

   // walk from the farthest candidate back to start so the nearest requester wins
   always_comb begin
      grant   = start;
      any_req = |req;
      idx     = '0;
      for (int k = NUM_WAYS - 1; k >= 0; k--) begin
         idx = W'((int'(start) + k) % NUM_WAYS);
         if (req[idx]) grant = idx;
      end
   end

endmodule

// File: rtl/traffic_light_controller_nway.sv
// traffic_light_controller_nway: round-robin N-approach signal controller; EMERGENCY_PREEMPT_EN adds emergency preemption
module traffic_light_controller_nway
   import traffic_pkg::*;
#(
   parameter int NUM_WAYS    = 4,
   parameter int TIMER_W     = 8,
   parameter int MIN_GREEN   = 5,
   parameter int MAX_GREEN   = 20,
   parameter int YELLOW_TIME = 2,
   parameter int ALLRED_TIME = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_WAYS-1:0]         sense,
`ifdef EMERGENCY_PREEMPT_EN
   input  logic                        emerg_req,
   input  logic [$clog2(NUM_WAYS)-1:0] emerg_way,
`endif
   output logic [NUM_WAYS-1:0]         red,
   output logic [NUM_WAYS-1:0]         yellow,
   output logic [NUM_WAYS-1:0]         green,
   output logic [$clog2(NUM_WAYS)-1:0] active_way,
   output logic [1:0]                  phase
);

   localparam int W = $clog2(NUM_WAYS);
   localparam logic [TIMER_W-1:0] min_lim = TIMER_W'(MIN_GREEN - 1);
   localparam logic [TIMER_W-1:0] max_lim = TIMER_W'(MAX_GREEN - 1);
   localparam logic [TIMER_W-1:0] yel_lim = TIMER_W'(YELLOW_TIME - 1);
   localparam logic [TIMER_W-1:0] red_lim = TIMER_W'(ALLRED_TIME - 1);

   if (NUM_WAYS < 2 || MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN || YELLOW_TIME < 1 ||
       ALLRED_TIME < 1 || MAX_GREEN >= 2**TIMER_W || YELLOW_TIME >= 2**TIMER_W ||
       ALLRED_TIME >= 2**TIMER_W) begin : g_param_err
      $error("traffic_light_controller_nway: illegal parameter set");
   end

   logic [TIMER_W-1:0]  cnt;
   logic [W-1:0]        target;
   logic [W-1:0]        start;
   logic [W-1:0]        grant;
   logic [W-1:0]        next_target;
   logic [NUM_WAYS-1:0] others;
   logic                other_req;
   logic                contest_exit;
   logic                green_exit;

   rr_way_select #(.NUM_WAYS(NUM_WAYS)) u_sel (
      .req     (others),
      .start   (start),
      .grant   (grant),
      .any_req (other_req)
   );

   // decide whether the current green ends at this edge and who is served next
   always_comb begin
      others       = sense & ~(NUM_WAYS'(1) << active_way);
      start        = (active_way == W'(NUM_WAYS - 1)) ? '0 : active_way + 1'b1;
      contest_exit = other_req && ((cnt >= min_lim && !sense[active_way]) || cnt >= max_lim);
`ifdef EMERGENCY_PREEMPT_EN
      green_exit   = emerg_req ? (emerg_way != active_way) : contest_exit;
      next_target  = (emerg_req && emerg_way != active_way) ? emerg_way : grant;
`else
      green_exit   = contest_exit;
      next_target  = grant;
`endif
   end

   // phase sequencer: green -> yellow -> all-red -> green on target; cnt restarts on each entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase      <= PH_GREEN;
         active_way <= '0;
         cnt        <= '0;
         target     <= '0;
      end else if (phase == PH_GREEN && green_exit) begin
         phase  <= PH_YELLOW;
         target <= next_target;
         cnt    <= '0;
      end else if (phase == PH_YELLOW && cnt >= yel_lim) begin
         phase <= PH_ALLRED;
         cnt   <= '0;
      end else if (phase == PH_ALLRED && cnt >= red_lim) begin
         phase      <= PH_GREEN;
         active_way <= target;
         cnt        <= '0;
      end else if (phase == 2'd3) begin
         phase <= PH_ALLRED;
         cnt   <= '0;
      end else if (cnt != '1) begin
         cnt <= cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_WAYS; i++) begin : g_lamp
      assign {red[i], yellow[i], green[i]} = lamp_decode(phase, active_way == W'(i));
   end

endmodule

// File: tb/tb_traffic_light_controller_nway.sv
// tb_traffic_light_controller_nway: table-driven scoreboard bench for the 4-way controller
module tb_traffic_light_controller_nway;

   localparam logic [1:0] G = 2'd0, Y = 2'd1, R = 2'd2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] sense = 4'b0000;
   logic [3:0] red, yellow, green;
   logic [1:0] active_way, phase;
`ifdef EMERGENCY_PREEMPT_EN
   logic       emerg_req = 1'b0;
   logic [1:0] emerg_way = 2'd0;
`endif

   always #5 clk = ~clk;

   traffic_light_controller_nway dut (
      .clk        (clk),
      .reset      (reset),
      .sense      (sense),
`ifdef EMERGENCY_PREEMPT_EN
      .emerg_req  (emerg_req),
      .emerg_way  (emerg_way),
`endif
      .red        (red),
      .yellow     (yellow),
      .green      (green),
      .active_way (active_way),
      .phase      (phase)
   );

   typedef struct {
      bit         rst;
      logic [3:0] sense;
      bit         er;
      logic [1:0] ew;
      logic [1:0] ph;
      logic [1:0] way;
      int         reps;
   } vec_t;

   typedef struct {
      logic [1:0] ph;
      logic [1:0] way;
      string      name;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check_out();
      exp_t e;
      logic [3:0] oh, eg, ey, er;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL scoreboard: got empty queue, want an expected entry");
         return;
      end
      e  = sb.pop_front();
      oh = 4'b0001 << e.way;
      eg = (e.ph == G) ? oh : 4'b0000;
      ey = (e.ph == Y) ? oh : 4'b0000;
      er = ~(eg | ey);
      if (phase !== e.ph || active_way !== e.way || green !== eg || yellow !== ey || red !== er) begin
         fails++;
         $display("FAIL %s: got ph=%0d way=%0d g=%b y=%b r=%b, want ph=%0d way=%0d g=%b y=%b r=%b",
                  e.name, phase, active_way, green, yellow, red, e.ph, e.way, eg, ey, er);
      end
   endtask

   task automatic do_reset(input string name);
      reset = 1'b1;
      #1;
      sb.push_back('{G, 2'd0, name});
      check_out();
      tests++;
      if (dut.cnt !== '0) begin
         fails++;
         $display("FAIL %s.cnt: got %0d, want 0", name, dut.cnt);
      end
      #2;
      reset = 1'b0;
   endtask

   task automatic step(input vec_t v, input string name);
      sense = v.sense;
`ifdef EMERGENCY_PREEMPT_EN
      emerg_req = v.er;
      emerg_way = v.ew;
`endif
      sb.push_back('{v.ph, v.way, name});
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by 100000, want finish");
      $fatal(1);
   end

   initial begin
      // reset held across edges with full demand must keep the reset state
      sense = 4'b1111;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         sb.push_back('{G, 2'd0, $sformatf("rst_hold%0d", k)});
         check_out();
      end
      reset = 1'b0;
      // single competitor: min green then clearance, then handover to way 2, then leave via yellow
      vecs.push_back('{1, 4'b0100, 0, 2'd0, G, 2'd0, 4});
      vecs.push_back('{0, 4'b0100, 0, 2'd0, Y, 2'd0, 2});
      vecs.push_back('{0, 4'b0100, 0, 2'd0, R, 2'd0, 1});
      vecs.push_back('{0, 4'b0100, 0, 2'd0, G, 2'd2, 5});
      vecs.push_back('{0, 4'b0001, 0, 2'd0, Y, 2'd2, 1});
      // asynchronous reset lands mid-yellow on way 2, then no demand holds way 0
      vecs.push_back('{1, 4'b0000, 0, 2'd0, G, 2'd0, 50});
      // full demand: max green rotation 0,1,2,3,0
      vecs.push_back('{1, 4'b1111, 0, 2'd0, G, 2'd0, 19});
      vecs.push_back('{0, 4'b1111, 0, 2'd0, Y, 2'd0, 2});
      vecs.push_back('{0, 4'b1111, 0, 2'd0, R, 2'd0, 1});
      vecs.push_back('{0, 4'b1111, 0, 2'd0, G, 2'd1, 20});
      vecs.push_back('{0, 4'b1111, 0, 2'd0, Y, 2'd1, 2});
      vecs.push_back('{0, 4'b1111, 0, 2'd0, R, 2'd1, 1});
      vecs.push_back('{0, 4'b1111, 0, 2'd0, G, 2'd2, 20});
      vecs.push_back('{0, 4'b1111, 0, 2'd0, Y, 2'd2, 2});
      vecs.push_back('{0, 4'b1111, 0, 2'd0, R, 2'd2, 1});
      vecs.push_back('{0, 4'b1111, 0, 2'd0, G, 2'd3, 20});
      vecs.push_back('{0, 4'b1111, 0, 2'd0, Y, 2'd3, 2});
      vecs.push_back('{0, 4'b1111, 0, 2'd0, R, 2'd3, 1});
      vecs.push_back('{0, 4'b1111, 0, 2'd0, G, 2'd0, 20});
      // wrap 3 -> 1, with demand dropped during yellow and all-red
      vecs.push_back('{1, 4'b1000, 0, 2'd0, G, 2'd0, 4});
      vecs.push_back('{0, 4'b1000, 0, 2'd0, Y, 2'd0, 2});
      vecs.push_back('{0, 4'b1000, 0, 2'd0, R, 2'd0, 1});
      vecs.push_back('{0, 4'b1000, 0, 2'd0, G, 2'd3, 1});
      vecs.push_back('{0, 4'b0010, 0, 2'd0, G, 2'd3, 4});
      vecs.push_back('{0, 4'b0010, 0, 2'd0, Y, 2'd3, 1});
      vecs.push_back('{0, 4'b0000, 0, 2'd0, Y, 2'd3, 1});
      vecs.push_back('{0, 4'b0000, 0, 2'd0, R, 2'd3, 1});
      vecs.push_back('{0, 4'b0000, 0, 2'd0, G, 2'd1, 5});
`ifdef EMERGENCY_PREEMPT_EN
      // preempt way 0 at cnt=1 for way 3, hold past max green, then release
      vecs.push_back('{1, 4'b0000, 0, 2'd0, G, 2'd0, 1});
      vecs.push_back('{0, 4'b0000, 1, 2'd3, Y, 2'd0, 2});
      vecs.push_back('{0, 4'b0000, 1, 2'd3, R, 2'd0, 1});
      vecs.push_back('{0, 4'b1111, 1, 2'd3, G, 2'd3, 25});
      vecs.push_back('{0, 4'b1111, 0, 2'd0, Y, 2'd3, 2});
      vecs.push_back('{0, 4'b1111, 0, 2'd0, R, 2'd3, 1});
      vecs.push_back('{0, 4'b1111, 0, 2'd0, G, 2'd0, 1});
`endif
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset($sformatf("vec%0d.reset", i));
         for (int k = 0; k < vecs[i].reps; k++) step(vecs[i], $sformatf("vec%0d.%0d", i, k));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
